hs_bl: RTL and testbench

- Registered bit-wise half subtractor array.
- Each lane computes difference = ip1 − ip2 and borrow-out for one bit pair, with no borrow-in.
- WIDTH independent lanes are computed in parallel. Results are captured in an output register stage with a valid flag.
- Used as a leaf arithmetic primitive and as a building block for ripple/full subtractors elsewhere in the datapath.

---
 rtl/hs_bit.sv | 12 +
 rtl/hs_bl.sv | 59 +++++
 tb/tb_hs_bl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hs_bit.sv
// Single-bit half subtractor: d = a - b (mod 2), bo = borrow-out. Purely combinational.
module hs_bit (
    input  logic a,
    input  logic b,
    output logic bo,
    output logic d
);

    assign d  = a ^ b;
    assign bo = ~a & b;

endmodule

// File: rtl/hs_bl.sv
// Registered array of WIDTH independent half-subtractor lanes with a one-cycle valid pipeline.
// Port names are fixed by the datapath integration and are therefore not suffixed.
module hs_bl #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    output logic [WIDTH-1:0] borrow,
    output logic [WIDTH-1:0] difference,
    output logic             out_valid
);

    logic [WIDTH-1:0] borrow_c;
    logic [WIDTH-1:0] difference_c;
    logic [WIDTH-1:0] borrow_d,     borrow_q;
    logic [WIDTH-1:0] difference_d, difference_q;
    logic             out_valid_d,  out_valid_q;

    // Independent lanes, no borrow chaining between bits.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
        hs_bit u_hs_bit (
            .a  (ip1[i]),
            .b  (ip2[i]),
            .bo (borrow_c[i]),
            .d  (difference_c[i])
        );
    end

    // Results hold when nothing is accepted; out_valid pulses once per accepted input.
    always_comb begin
        borrow_d     = borrow_q;
        difference_d = difference_q;
        out_valid_d  = in_valid;
        if (in_valid) begin
            borrow_d     = borrow_c;
            difference_d = difference_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            borrow_q     <= '0;
            difference_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            borrow_q     <= borrow_d;
            difference_q <= difference_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign borrow     = borrow_q;
    assign difference = difference_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_hs_bl.sv
// Self-checking bench for hs_bl at WIDTH 1, 4 and 8 against an arithmetic per-lane model.
module tb_hs_bl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v1, v4, v8;
    logic [0:0] a1, b1, bo1, d1;
    logic [3:0] a4, b4, bo4, d4;
    logic [7:0] a8, b8, bo8, d8;
    logic       ov1, ov4, ov8;

    int checks = 0;
    int errors = 0;

    hs_bl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .ip1(a1), .ip2(b1),
        .borrow(bo1), .difference(d1), .out_valid(ov1)
    );
    hs_bl #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .ip1(a4), .ip2(b4),
        .borrow(bo4), .difference(d4), .out_valid(ov4)
    );
    hs_bl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .ip1(a8), .ip2(b8),
        .borrow(bo8), .difference(d8), .out_valid(ov8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per lane: compute a - b as an integer; borrow when negative, difference bit is that value mod 2.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] bo, output logic [63:0] d);
        bo = '0;
        d  = '0;
        for (int i = 0; i < w; i++) begin
            int x;
            x     = int'(a[i]) - int'(b[i]);
            bo[i] = (x < 0);
            d[i]  = ((x + 2) % 2) != 0;
        end
    endfunction

    initial begin
        logic [63:0] eb, ed;
        logic [3:0]  tt_a, tt_b;
        int          accepted;
        int          seen;
        int          iter;
        logic        vr;

        rst_n = 1'b0;
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;

        // Reset state held across clock edges.
        #22;
        chk("rst_bo8", 64'(bo8), 64'd0);
        chk("rst_d8",  64'(d8),  64'd0);
        chk("rst_ov8", 64'(ov8), 64'd0);
        chk("rst_ov1", 64'(ov1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table on successive edges.
        tt_a = 4'b1100;
        tt_b = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v1 = 1'b1;
            a1 = tt_a[k];
            b1 = tt_b[k];
            @(posedge clk);
            #1;
            model(1, 64'(a1), 64'(b1), eb, ed);
            chk("tt_bo", 64'(bo1), eb);
            chk("tt_d",  64'(d1),  ed);
            chk("tt_ov", 64'(ov1), 64'd1);
        end

        // Hold: a valid 0-1, then 1-1 without in_valid.
        @(negedge clk);
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_bo_a", 64'(bo1), 64'd1);
        chk("hold_d_a",  64'(d1),  64'd1);
        chk("hold_ov_a", 64'(ov1), 64'd1);
        @(negedge clk);
        v1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_bo_b", 64'(bo1), 64'd1);
        chk("hold_d_b",  64'(d1),  64'd1);
        chk("hold_ov_b", 64'(ov1), 64'd0);

        // WIDTH=4 directed lanes.
        @(negedge clk);
        v4 = 1'b1; a4 = 4'b1010; b4 = 4'b0110;
        @(posedge clk);
        #1;
        model(4, 64'(a4), 64'(b4), eb, ed);
        chk("w4_bo", 64'(bo4), eb);
        chk("w4_d",  64'(d4),  ed);
        chk("w4_bo_const", 64'(bo4), 64'h4);
        chk("w4_d_const",  64'(d4),  64'hC);
        chk("w4_ov", 64'(ov4), 64'd1);
        @(negedge clk);
        v4 = 1'b0;

        // Async reset mid-stream: outputs clear at once, in-flight input never emerges.
        @(negedge clk);
        v8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3;
        @(posedge clk);
        #1;
        chk("ar_pre_ov", 64'(ov8), 64'd1);
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'hF0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_bo", 64'(bo8), 64'd0);
        chk("ar_d",  64'(d8),  64'd0);
        chk("ar_ov", 64'(ov8), 64'd0);
        @(posedge clk);
        #1;
        chk("ar_low_ov", 64'(ov8), 64'd0);
        chk("ar_low_bo", 64'(bo8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v8 = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_post_ov", 64'(ov8), 64'd0);
        chk("ar_post_d",  64'(d8),  64'd0);

        // WIDTH=8 random stream with gaps.
        eb = '0;
        ed = '0;
        accepted = 0;
        seen = 0;
        iter = 0;
        while (accepted < 1000 && iter < 3000) begin
            iter++;
            @(negedge clk);
            vr = ($urandom_range(0, 3) != 0);
            v8 = vr;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(posedge clk);
            #1;
            if (vr) begin
                accepted++;
                model(8, 64'(a8), 64'(b8), eb, ed);
            end
            chk("rnd_bo", 64'(bo8), eb);
            chk("rnd_d",  64'(d8),  ed);
            chk("rnd_ov", 64'(ov8), 64'(vr));
            if (ov8 === 1'b1) seen++;
        end
        @(negedge clk);
        v8 = 1'b0;
        chk("rnd_accepted", 64'(accepted), 64'd1000);
        chk("rnd_ov_count", 64'(seen), 64'(accepted));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
